nios_system_sysid_checker: RTL and testbench

Boot-time sequencer that drives the system-ID Avalon-MM slave as a master. On `start` it reads word 0 (system ID) and then word 1 (build timestamp), and compares both against expected values. It reports match/mismatch status to the CPU status register block and the LED debug logic. It tolerates wait states, times out stalled reads, and retries a bounded number of times.

---
 rtl/nios_system_sysid_checker.sv | 169 ++++++++++++++++
 tb/tb_nios_system_sysid_checker.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/nios_system_sysid_checker.sv
// Boot-time system-ID checker: reads sysid words 0 and 1 as an Avalon-MM master
// and compares them against the expected build values, with timeout and retry.
module nios_system_sysid_checker #(
   parameter logic [31:0] EXPECTED_ID    = 32'd0,
   parameter logic [31:0] EXPECTED_TS    = 32'd1476750919,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned MAX_RETRIES    = 3
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        error,
   output logic [31:0] read_id,
   output logic [31:0] read_ts
);

   localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);
   localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_ID,
      S_RD_TS,
      S_GAP,
      S_CHECK,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic        gap_ts_q, gap_ts_d;
   logic [3:0]  retry_q, retry_d;
   logic [15:0] tmo_q, tmo_d;
   logic        done_q, done_d;
   logic        id_ok_q, id_ok_d;
   logic        ts_ok_q, ts_ok_d;
   logic        error_q, error_d;
   logic [31:0] read_id_q, read_id_d;
   logic [31:0] read_ts_q, read_ts_d;
   logic        avm_read_q, avm_read_d;
   logic        avm_address_q, avm_address_d;
   logic        busy_q, busy_d;
   logic [15:0] tmo_inc;

   assign tmo_inc = tmo_q + 16'd1;

   always_comb begin
      state_d   = state_q;
      gap_ts_d  = gap_ts_q;
      retry_d   = retry_q;
      tmo_d     = tmo_q;
      done_d    = done_q;
      id_ok_d   = id_ok_q;
      ts_ok_d   = ts_ok_q;
      error_d   = error_q;
      read_id_d = read_id_q;
      read_ts_d = read_ts_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_RD_ID;
               done_d  = 1'b0;
               id_ok_d = 1'b0;
               ts_ok_d = 1'b0;
               error_d = 1'b0;
               retry_d = 4'd0;
               tmo_d   = 16'd0;
            end
         end
         S_RD_ID, S_RD_TS: begin
            // Completion is tested first so it wins over a coincident timeout.
            if (!avm_waitrequest) begin
               tmo_d = 16'd0;
               if (state_q == S_RD_ID) begin
                  read_id_d = avm_readdata;
                  state_d   = S_RD_TS;
               end else begin
                  read_ts_d = avm_readdata;
                  state_d   = S_CHECK;
               end
            end else if (tmo_inc == TMO_LIMIT) begin
               tmo_d = 16'd0;
               if (retry_q < RETRY_MAX) begin
                  retry_d  = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
                  gap_ts_d = (state_q == S_RD_TS);
                  state_d  = S_GAP;
               end else begin
                  done_d  = 1'b1;
                  error_d = 1'b1;
                  id_ok_d = 1'b0;
                  ts_ok_d = 1'b0;
                  state_d = S_DONE;
               end
            end else begin
               tmo_d = tmo_inc;
            end
         end
         S_GAP: begin
            state_d = gap_ts_q ? S_RD_TS : S_RD_ID;
         end
         S_CHECK: begin
            id_ok_d = (read_id_q == EXPECTED_ID);
            ts_ok_d = (read_ts_q == EXPECTED_TS);
            done_d  = 1'b1;
            state_d = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Bus and busy outputs are registered from the upcoming state.
      avm_read_d    = (state_d == S_RD_ID) || (state_d == S_RD_TS);
      avm_address_d = (state_d == S_RD_TS);
      busy_d        = (state_d == S_RD_ID) || (state_d == S_RD_TS) ||
                      (state_d == S_GAP)   || (state_d == S_CHECK);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         gap_ts_q      <= 1'b0;
         retry_q       <= 4'd0;
         tmo_q         <= 16'd0;
         done_q        <= 1'b0;
         id_ok_q       <= 1'b0;
         ts_ok_q       <= 1'b0;
         error_q       <= 1'b0;
         read_id_q     <= 32'd0;
         read_ts_q     <= 32'd0;
         avm_read_q    <= 1'b0;
         avm_address_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         gap_ts_q      <= gap_ts_d;
         retry_q       <= retry_d;
         tmo_q         <= tmo_d;
         done_q        <= done_d;
         id_ok_q       <= id_ok_d;
         ts_ok_q       <= ts_ok_d;
         error_q       <= error_d;
         read_id_q     <= read_id_d;
         read_ts_q     <= read_ts_d;
         avm_read_q    <= avm_read_d;
         avm_address_q <= avm_address_d;
         busy_q        <= busy_d;
      end
   end

   assign avm_read    = avm_read_q;
   assign avm_address = avm_address_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign id_ok       = id_ok_q;
   assign ts_ok       = ts_ok_q;
   assign error       = error_q;
   assign read_id     = read_id_q;
   assign read_ts     = read_ts_q;

endmodule

// File: tb/tb_nios_system_sysid_checker.sv
// Directed bench for the sysid checker: a small sysid slave model, a result
// scoreboard and a per-cycle trace of the read strobe and address.
module tb_nios_system_sysid_checker;

   localparam logic [31:0] TS = 32'd1476750919;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        start;
   logic        avm_address;
   logic        avm_read;
   logic [31:0] avm_readdata;
   logic        avm_waitrequest;
   logic        busy, done, id_ok, ts_ok, error;
   logic [31:0] read_id, read_ts;

   logic [31:0] id_val, ts_val;
   logic [31:0] last_id, last_ts;
   int          ts_stall;
   bit          stuck;
   bit          rec;
   int          n_vec = 0;
   int          n_err = 0;
   logic [1:0]  trace[$];

   typedef struct {
      logic        id_ok;
      logic        ts_ok;
      logic        err;
      logic [31:0] rid;
      logic [31:0] rts;
      int          lat;
   } exp_t;
   exp_t sb[$];

   nios_system_sysid_checker #(
      .EXPECTED_ID    (32'd0),
      .EXPECTED_TS    (TS),
      .TIMEOUT_CYCLES (8),
      .MAX_RETRIES    (2)
   ) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .start           (start),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_readdata    (avm_readdata),
      .avm_waitrequest (avm_waitrequest),
      .busy            (busy),
      .done            (done),
      .id_ok           (id_ok),
      .ts_ok           (ts_ok),
      .error           (error),
      .read_id         (read_id),
      .read_ts         (read_ts)
   );

   always #5 clock = ~clock;

   // Slave data is only valid when not stalling.
   assign avm_readdata = avm_waitrequest ? 32'hDEADBEEF : (avm_address ? ts_val : id_val);

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge, record the bus, then set waitrequest for the next rising edge.
   task automatic cycle();
      @(negedge clock);
      if (rec) trace.push_back({avm_read, avm_address});
      if (stuck) begin
         avm_waitrequest = 1'b1;
      end else if (avm_read && avm_address && ts_stall > 0) begin
         avm_waitrequest = 1'b1;
         ts_stall--;
      end else begin
         avm_waitrequest = 1'b0;
      end
   endtask

   function automatic int count_tr(input logic [1:0] v);
      int c = 0;
      foreach (trace[i]) if (trace[i] === v) c++;
      return c;
   endfunction

   task automatic run(input string tag, input int extra, input logic eid, input logic ets,
                      input logic eerr, input int elat);
      exp_t e;
      int   lat;
      if (!eerr) begin
         last_id = id_val;
         last_ts = ts_val;
      end
      e.id_ok = eid;
      e.ts_ok = ets;
      e.err   = eerr;
      e.rid   = last_id;
      e.rts   = last_ts;
      e.lat   = elat;
      sb.push_back(e);

      trace.delete();
      rec   = 1'b1;
      start = 1'b1;
      cycle();
      start = 1'b0;
      chk({tag, " accept busy"}, 32'(busy), 32'd1);
      chk({tag, " accept clear"}, 32'({done, id_ok, ts_ok, error}), 32'd0);
      lat = 0;
      while (done !== 1'b1 && lat < 60) begin
         start = (lat == extra);
         cycle();
         start = 1'b0;
         lat++;
      end
      rec = 1'b0;

      e = sb.pop_front();
      chk({tag, " latency"}, lat, e.lat);
      chk({tag, " done"}, 32'(done), 32'd1);
      chk({tag, " busy"}, 32'(busy), 32'd0);
      chk({tag, " id_ok"}, 32'(id_ok), 32'(e.id_ok));
      chk({tag, " ts_ok"}, 32'(ts_ok), 32'(e.ts_ok));
      chk({tag, " error"}, 32'(error), 32'(e.err));
      chk({tag, " read_id"}, read_id, e.rid);
      chk({tag, " read_ts"}, read_ts, e.rts);
   endtask

   initial begin
      reset_n         = 1'b0;
      start           = 1'b0;
      avm_waitrequest = 1'b0;
      stuck           = 1'b0;
      rec             = 1'b0;
      ts_stall        = 0;
      id_val          = 32'd0;
      ts_val          = TS;
      last_id         = 32'd0;
      last_ts         = 32'd0;
      cycle();
      cycle();
      chk("reset outs", 32'({avm_read, avm_address, busy, done, id_ok, ts_ok, error}), 32'd0);
      chk("reset read_id", read_id, 32'd0);
      chk("reset read_ts", read_ts, 32'd0);
      reset_n = 1'b1;
      cycle();

      // Zero-wait check with correct values.
      run("t1", -1, 1'b1, 1'b1, 1'b0, 3);
      chk("t1 addr0 cycle", 32'(trace[0]), 32'd2);
      chk("t1 addr1 cycle", 32'(trace[1]), 32'd3);
      chk("t1 check cycle", 32'(trace[2]), 32'd0);
      chk("t1 read_ts dec", read_ts, 32'd1476750919);

      // Timestamp off by one.
      ts_val = TS + 32'd1;
      run("t2", -1, 1'b1, 1'b0, 1'b0, 3);

      // Four wait states on the timestamp read.
      ts_val   = TS;
      ts_stall = 4;
      run("t3", -1, 1'b1, 1'b1, 1'b0, 7);
      chk("t3 ts read held", 32'(count_tr(2'b11)), 32'd5);
      chk("t3 id reads", 32'(count_tr(2'b10)), 32'd1);

      // Slave stuck: three timeouts with two gap cycles, then error.
      stuck = 1'b1;
      run("t4", -1, 1'b0, 1'b0, 1'b1, 26);
      chk("t4 read cycles", 32'(count_tr(2'b10)), 32'd24);
      chk("t4 gaps", 32'(count_tr(2'b00) - 1), 32'd2);
      stuck = 1'b0;

      // One timeout on the timestamp read, then a good response.
      ts_stall = 8;
      run("t5", -1, 1'b1, 1'b1, 1'b0, 12);
      chk("t5 id reads", 32'(count_tr(2'b10)), 32'd1);
      chk("t5 ts reads", 32'(count_tr(2'b11)), 32'd9);

      // Reset in the middle of the timestamp read.
      ts_stall = 6;
      start    = 1'b1;
      cycle();
      start = 1'b0;
      cycle();
      cycle();
      chk("t6 pre-reset read", 32'({avm_read, avm_address}), 32'd3);
      reset_n = 1'b0;
      #1;
      chk("t6 async read drop", 32'(avm_read), 32'd0);
      chk("t6 reset outs", 32'({avm_address, busy, done, id_ok, ts_ok, error}), 32'd0);
      chk("t6 reset read_id", read_id, 32'd0);
      chk("t6 reset read_ts", read_ts, 32'd0);
      ts_stall = 0;
      cycle();
      reset_n = 1'b1;
      last_id = 32'd0;
      last_ts = 32'd0;
      cycle();

      // Start pulsed while busy in RD_TS must be ignored.
      id_val   = 32'h0000_0001;
      ts_stall = 6;
      run("t6a", 1, 1'b0, 1'b1, 1'b0, 9);
      chk("t6a id reads", 32'(count_tr(2'b10)), 32'd1);

      // A fresh start after done reruns and clears the old status.
      id_val = 32'd0;
      run("t6b", -1, 1'b1, 1'b1, 1'b0, 3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
